mac_acc_drain: RTL and testbench

- Downstream consumer of the 8x8 MAC unit.
- Counts a programmed number of accumulated products, snapshots the 16-bit accumulator, scales it with saturation, and queues results in a small FIFO.
- Results leave through a valid/ready interface.
- Issues a one-cycle clear to the MAC after every snapshot, so each dot product starts from zero.

---
 rtl/mac_acc_drain_if.sv | 24 ++
 rtl/mac_acc_drain.sv | 134 +++++++++++++
 tb/tb_mac_acc_drain.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mac_acc_drain_if.sv
// Result stream interface for mac_acc_drain.
// The master drives the FIFO head; the slave returns ready.
interface mac_acc_drain_if #(
  parameter int OUT_W = 8
);
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_sat;

  modport master (
    output out_valid,
    output out_data,
    output out_sat,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_sat,
    output out_ready
  );
endinterface

// File: rtl/mac_acc_drain.sv
// MAC drain: counts products, snapshots, scales with saturation, queues.
// Optional round-to-nearest before the shift: MAC_DRAIN_ROUND_EN.
module mac_acc_drain #(
  parameter int ACC_W = 16,
  parameter int OUT_W = 8,
  parameter int SHIFT = 8,
  parameter int LEN_W = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             acc_valid,
  input  logic [ACC_W-1:0] accumulator,
  output logic             mac_clear,
  output logic             busy,
  output logic             lost,
  mac_acc_drain_if.master  out
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    PUSH,
    CLEAR
  } state_t;

`ifdef MAC_DRAIN_ROUND_EN
  localparam logic [ACC_W:0] RND =
    ((ACC_W+1)'(1) << SHIFT) >> 1;
`else
  localparam logic [ACC_W:0] RND = '0;
`endif

  state_t           state_q;
  logic [LEN_W-1:0] count_q;
  logic [LEN_W-1:0] len_q;
  logic [ACC_W-1:0] snap_q;
  logic             lost_q;
  logic             clr_q;

  logic [OUT_W:0]   mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;

  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  logic [ACC_W:0]   sum;
  logic [ACC_W:0]   v;
  logic             sat;
  logic [OUT_W-1:0] data;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop   = !empty && out.out_ready;
  assign push  = (state_q == PUSH) && (!full || pop);

  // Sum is one bit wider than the snapshot so rounding never wraps.
  assign sum  = {1'b0, snap_q} + RND;
  assign v    = sum >> SHIFT;
  assign sat  = |v[ACC_W:OUT_W];
  assign data = sat ? '1 : v[OUT_W-1:0];

  assign mac_clear     = clr_q;
  assign busy          = (state_q != IDLE);
  assign lost          = lost_q;
  assign out.out_valid = !empty;
  assign out.out_data  = mem_q[rptr_q[AW-1:0]][OUT_W-1:0];
  assign out.out_sat   = mem_q[rptr_q[AW-1:0]][OUT_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      len_q   <= '0;
      snap_q  <= '0;
      lost_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      clr_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start && (len != '0)) begin
            len_q   <= len;
            count_q <= '0;
            state_q <= COUNT;
          end
        end
        COUNT: begin
          if (acc_valid) begin
            if (count_q == len_q - LEN_W'(1)) begin
              snap_q  <= accumulator;
              state_q <= PUSH;
            end
            count_q <= count_q + LEN_W'(1);
          end
        end
        PUSH: begin
          if (acc_valid) lost_q <= 1'b1;
          if (push) begin
            clr_q   <= 1'b1;
            state_q <= CLEAR;
          end
        end
        CLEAR: begin
          if (acc_valid) lost_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q[AW-1:0]] <= {sat, data};
        wptr_q <= wptr_q + (AW+1)'(1);
      end
      if (pop) rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

endmodule

// File: tb/tb_mac_acc_drain.sv
// Scoreboard bench for mac_acc_drain.
// Expected words are queued at capture and checked on each pop.
module tb_mac_acc_drain;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  len;
  logic        acc_valid;
  logic [15:0] accumulator;
  logic        mac_clear;
  logic        busy;
  logic        lost;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;
  int base;
  logic [8:0] sb [$];

  mac_acc_drain_if #(.OUT_W(8)) bus ();

  mac_acc_drain dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .len         (len),
    .acc_valid   (acc_valid),
    .accumulator (accumulator),
    .mac_clear   (mac_clear),
    .busy        (busy),
    .lost        (lost),
    .out         (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] conv(input logic [15:0] a);
    int v;
`ifdef MAC_DRAIN_ROUND_EN
    v = (int'(a) + 128) >> 8;
`else
    v = int'(a) >> 8;
`endif
    if (v > 255) return 9'h1FF;
    return {1'b0, 8'(v)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run1(input logic [15:0] a);
    start = 1'b1;
    len   = 8'd1;
    tick();
    start       = 1'b0;
    acc_valid   = 1'b1;
    accumulator = a;
    sb.push_back(conv(a));
    tick();
    acc_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        chk("pop_word",
            {23'd0, bus.out_sat, bus.out_data},
            {23'd0, sb.pop_front()});
      end
      pops++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    len = 8'd0;
    acc_valid = 1'b0;
    accumulator = 16'd0;
    bus.out_ready = 1'b1;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_lost", lost, 0);
    chk("rst_clear", mac_clear, 0);
    chk("rst_valid", bus.out_valid, 0);
    tick();
    reset = 1'b0;

    start = 1'b1;
    len   = 8'd3;
    tick();
    start = 1'b0;
    acc_valid = 1'b1;
    accumulator = 16'h1000;
    tick();
    accumulator = 16'h1100;
    tick();
    accumulator = 16'h1234;
    sb.push_back(9'h012);
    tick();
    acc_valid = 1'b0;
    chk("t1_push_valid", bus.out_valid, 0);
    chk("t1_push_busy", busy, 1);
    chk("t1_push_clear", mac_clear, 0);
    tick();
    chk("t1_lat_valid", bus.out_valid, 1);
    chk("t1_clear_pulse", mac_clear, 1);
    tick();
    chk("t1_idle_clear", mac_clear, 0);
    chk("t1_idle_busy", busy, 0);

    run1(16'hFFFF);
    tick();
    tick();
    run1(16'h1280);
    tick();
    tick();
    run1(16'h00FF);
    tick();
    tick();

    bus.out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      run1(16'(k * 256));
      tick();
      tick();
    end
    run1(16'h0500);
    tick();
    tick();
    chk("full_busy", busy, 1);
    chk("full_no_clear", mac_clear, 0);
    chk("full_lost0", lost, 0);
    acc_valid = 1'b1;
    accumulator = 16'hBEEF;
    tick();
    acc_valid = 1'b0;
    chk("full_lost1", lost, 1);
    chk("full_still_push", mac_clear, 0);
    base = pops;
    bus.out_ready = 1'b1;
    tick();
    chk("pp_clear", mac_clear, 1);
    chk("pp_valid", bus.out_valid, 1);
    for (int i = 0; i < 20 && bus.out_valid; i++) tick();
    chk("drain_empty", bus.out_valid, 0);
    chk("drain_pops", pops - base, 5);
    chk("drain_sb", sb.size(), 0);

    start = 1'b1;
    len   = 8'd0;
    tick();
    start = 1'b0;
    chk("len0_busy", busy, 0);
    start = 1'b1;
    len   = 8'd2;
    tick();
    len   = 8'd5;
    tick();
    start = 1'b0;
    acc_valid = 1'b1;
    accumulator = 16'h0300;
    tick();
    accumulator = 16'h0A00;
    sb.push_back(conv(16'h0A00));
    tick();
    acc_valid = 1'b0;
    chk("relen_busy", busy, 1);
    tick();
    chk("relen_clear", mac_clear, 1);
    tick();
    tick();
    chk("relen_sb", sb.size(), 0);

    start = 1'b1;
    len   = 8'd4;
    tick();
    start = 1'b0;
    acc_valid = 1'b1;
    accumulator = 16'h4000;
    tick();
    tick();
    acc_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_valid", bus.out_valid, 0);
    chk("mid_lost", lost, 0);
    chk("mid_clear", mac_clear, 0);
    tick();
    reset = 1'b0;
    base = pops;
    start = 1'b1;
    len   = 8'd2;
    tick();
    start = 1'b0;
    acc_valid = 1'b1;
    accumulator = 16'h0100;
    tick();
    accumulator = 16'h2345;
    sb.push_back(conv(16'h2345));
    tick();
    acc_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("post_pops", pops - base, 1);
    chk("post_sb", sb.size(), 0);
    chk("post_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
